// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch front end. Owns the PC, drives the instruction memory's
//   word-aligned read port, and buffers {pc, instr} pairs in a small FIFO for
//   decode. Supports branch/jump redirect (with flush) and halts on a
//   misaligned or out-of-range PC until redirected or reset.
//
// Parameters
//   RESET_PC    PC loaded on reset
//   FIFO_DEPTH  fetch buffer entries (power of two, >= 2)
//   IMEM_WORDS  instruction memory size in 32-bit words
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous active-high reset
//   imem_addr       byte address to instruction memory (the PC register)
//   imem_instr      instruction word returned combinationally for imem_addr
//   redirect_valid  load redirect_pc this cycle (flushes the buffer)
//   redirect_pc     redirect target
//   out_valid       FIFO head valid
//   out_ready       decode accepts the head
//   out_instr       instruction at FIFO head (holds last value when empty)
//   out_pc          PC of FIFO head (holds last value when empty)
//   fault           fetch halted on a bad PC
//   fault_pc        offending PC, held while fault is high
//
// Optional feature (macro FETCH_PERF_EN)
//   perf_fetched    instructions delivered (pops), wraps mod 2^64
//   perf_stall      RUN cycles with the buffer full and no pop
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2,
  parameter int          IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        fault,
  output logic [63:0] fault_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [63:0] perf_fetched,
  output logic [63:0] perf_stall
`endif
);

  localparam int             AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [61:0]    IMEM_LIMIT = 62'(IMEM_WORDS);

  typedef enum logic {S_RUN, S_FAULT} state_t;

  state_t        r_state;
  logic [63:0]   r_pc;
  logic [63:0]   r_fault_pc;
  logic [63:0]   r_hold_pc;
  logic [31:0]   r_hold_instr;
  logic [63:0]   r_mem_pc    [FIFO_DEPTH];
  logic [31:0]   r_mem_instr [FIFO_DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;

  logic          w_pop;
  logic          w_full;
  logic          w_pc_ok;
  logic          w_push;
  logic [63:0]   w_head_pc;
  logic [31:0]   w_head_instr;

  assign w_full       = (r_count == FULL_COUNT);
  assign w_pop        = out_valid & out_ready;
  assign w_pc_ok      = (r_pc[1:0] == 2'b00) && (r_pc[63:2] < IMEM_LIMIT);
  // A full buffer can still accept a push when the head leaves this cycle.
  assign w_push       = (r_state == S_RUN) && !redirect_valid && w_pc_ok &&
                        (!w_full || w_pop);
  assign w_head_pc    = r_mem_pc[r_rd_ptr];
  assign w_head_instr = r_mem_instr[r_rd_ptr];

  assign imem_addr = r_pc;
  assign out_valid = (r_count != '0);
  assign out_pc    = out_valid ? w_head_pc    : r_hold_pc;
  assign out_instr = out_valid ? w_head_instr : r_hold_instr;
  assign fault     = (r_state == S_FAULT);
  assign fault_pc  = r_fault_pc;

  // NOTE: buffer storage has no reset; r_count gates every read of it, so
  // reset only needs to clear the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_pc;
      r_mem_instr[r_wr_ptr] <= imem_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_RUN;
      r_pc         <= RESET_PC;
      r_fault_pc   <= '0;
      r_hold_pc    <= '0;
      r_hold_instr <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
    end else begin
      // Remember the current head so the outputs stay stable once empty.
      if (out_valid) begin
        r_hold_pc    <= w_head_pc;
        r_hold_instr <= w_head_instr;
      end

      if (redirect_valid) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
        r_pc     <= redirect_pc;
        if (redirect_pc[1:0] == 2'b00) begin
          r_state <= S_RUN;
        end else begin
          r_state    <= S_FAULT;
          r_fault_pc <= redirect_pc;
        end
      end else begin
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_pc     <= r_pc + 64'd4;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
        if ((r_state == S_RUN) && !w_pc_ok) begin
          r_state    <= S_FAULT;
          r_fault_pc <= r_pc;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [63:0] r_perf_fetched;
  logic [63:0] r_perf_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      // A pop in a redirect cycle is still a delivered instruction.
      if (w_pop) begin
        r_perf_fetched <= r_perf_fetched + 64'd1;
      end
      if ((r_state == S_RUN) && w_full && !w_pop) begin
        r_perf_stall <= r_perf_stall + 64'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. Directed scenarios plus a randomized
//   run compared against a queue-based transaction model. A second instance
//   with a 4-word memory exercises the out-of-range fault.
//   Define FETCH_PERF_EN to also check the performance counters.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int D = 2;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] imem [0:255];

  // Main instance (256-word memory)
  logic [63:0] imem_addr, redirect_pc, out_pc, fault_pc;
  logic [31:0] imem_instr, out_instr;
  logic        redirect_valid, out_valid, out_ready, fault;
  // Small instance (4-word memory)
  logic [63:0] s_imem_addr, s_redirect_pc, s_out_pc, s_fault_pc;
  logic [31:0] s_imem_instr, s_out_instr;
  logic        s_redirect_valid, s_out_valid, s_out_ready, s_fault;
`ifdef FETCH_PERF_EN
  logic [63:0] perf_fetched, perf_stall, s_perf_fetched, s_perf_stall;
`endif

  always_comb imem_instr   = (imem_addr[63:10] == 54'd0)   ? imem[imem_addr[9:2]]   : 32'hdead_beef;
  always_comb s_imem_instr = (s_imem_addr[63:10] == 54'd0) ? imem[s_imem_addr[9:2]] : 32'hdead_beef;

  fetch_unit #(.RESET_PC(64'h0), .FIFO_DEPTH(D), .IMEM_WORDS(256)) u_dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .fault(fault), .fault_pc(fault_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  fetch_unit #(.RESET_PC(64'h0), .FIFO_DEPTH(D), .IMEM_WORDS(4)) u_small (
    .clk(clk), .rst(rst),
    .imem_addr(s_imem_addr), .imem_instr(s_imem_instr),
    .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_instr(s_out_instr), .out_pc(s_out_pc),
    .fault(s_fault), .fault_pc(s_fault_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(s_perf_fetched), .perf_stall(s_perf_stall)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Holds reset for two cycles and releases it on a falling edge.
  task automatic reset_dut;
    @(negedge clk);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    out_ready      = 1'b0;
    s_out_ready    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    out_ready = 1'b1;
    rst = 1'b1;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_pc !== 64'h0) $display("FAIL reset_out_pc: got %h want 0", out_pc); else n_pass++;
    n_total++; if (out_instr !== 32'h0) $display("FAIL reset_out_instr: got %h want 0", out_instr); else n_pass++;
    n_total++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fault); else n_pass++;
    n_total++; if (fault_pc !== 64'h0) $display("FAIL reset_fault_pc: got %h want 0", fault_pc); else n_pass++;
    n_total++; if (imem_addr !== 64'h0) $display("FAIL reset_pc: got %h want 0", imem_addr); else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_release_valid: got %b want 0", out_valid); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b1 || out_pc !== 64'h0)
      $display("FAIL reset_first_fetch: got valid=%b pc=%h want valid=1 pc=0", out_valid, out_pc);
    else n_pass++;
  endtask

  task automatic test_stream;
    reset_dut();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_total++;
      if (out_valid !== 1'b1 || out_pc !== 64'(4 * k) || out_instr !== imem[k])
        $display("FAIL stream[%0d]: got valid=%b pc=%h instr=%h want 1 %h %h",
                 k, out_valid, out_pc, out_instr, 64'(4 * k), imem[k]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure;
    reset_dut();
    out_ready = 1'b0;
    repeat (5) tick();
    n_total++; if (out_valid !== 1'b1 || out_pc !== 64'h0)
      $display("FAIL bp_head: got valid=%b pc=%h want 1 0", out_valid, out_pc);
    else n_pass++;
    n_total++; if (imem_addr !== 64'h8) $display("FAIL bp_pc_hold: got %h want 8", imem_addr); else n_pass++;
`ifdef FETCH_PERF_EN
    n_total++; if (perf_stall !== 64'd3) $display("FAIL bp_perf_stall: got %0d want 3", perf_stall); else n_pass++;
    n_total++; if (perf_fetched !== 64'd0) $display("FAIL bp_perf_fetched: got %0d want 0", perf_fetched); else n_pass++;
`endif
    for (int k = 0; k < 6; k++) begin
      n_total++;
      if (out_valid !== 1'b1 || out_pc !== 64'(4 * k) || out_instr !== imem[k])
        $display("FAIL bp_resume[%0d]: got valid=%b pc=%h instr=%h want 1 %h %h",
                 k, out_valid, out_pc, out_instr, 64'(4 * k), imem[k]);
      else n_pass++;
      out_ready = 1'b1;
      tick();
    end
`ifdef FETCH_PERF_EN
    n_total++; if (perf_fetched !== 64'd6) $display("FAIL bp_perf_fetched_end: got %0d want 6", perf_fetched); else n_pass++;
    n_total++; if (perf_stall !== 64'd3) $display("FAIL bp_perf_stall_end: got %0d want 3", perf_stall); else n_pass++;
`endif
  endtask

  task automatic test_redirect;
    reset_dut();
    out_ready = 1'b1;
    repeat (2) tick();
    n_total++; if (out_valid !== 1'b1 || out_pc !== 64'h4)
      $display("FAIL redir_pre_head: got valid=%b pc=%h want 1 4", out_valid, out_pc);
    else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8;
    tick();
    redirect_valid = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL redir_flush: got %b want 0", out_valid); else n_pass++;
    n_total++; if (imem_addr !== 64'h8) $display("FAIL redir_pc: got %h want 8", imem_addr); else n_pass++;
`ifdef FETCH_PERF_EN
    n_total++; if (perf_fetched !== 64'd2) $display("FAIL redir_perf_fetched: got %0d want 2", perf_fetched); else n_pass++;
`endif
    tick();
    n_total++; if (out_valid !== 1'b1 || out_pc !== 64'h8 || out_instr !== 32'h002081b3)
      $display("FAIL redir_target: got valid=%b pc=%h instr=%h want 1 8 002081b3", out_valid, out_pc, out_instr);
    else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b1 || out_pc !== 64'hc)
      $display("FAIL redir_next: got valid=%b pc=%h want 1 c", out_valid, out_pc);
    else n_pass++;
  endtask

  task automatic test_fault_redirect;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h6;
    tick();
    redirect_valid = 1'b0;
    n_total++; if (fault !== 1'b1 || fault_pc !== 64'h6)
      $display("FAIL misalign_fault: got fault=%b fault_pc=%h want 1 6", fault, fault_pc);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (out_valid !== 1'b0 || fault !== 1'b1 || imem_addr !== 64'h6)
        $display("FAIL misalign_hold[%0d]: got valid=%b fault=%b pc=%h want 0 1 6", k, out_valid, fault, imem_addr);
      else n_pass++;
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0;
    tick();
    redirect_valid = 1'b0;
    n_total++; if (fault !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL fault_clear: got fault=%b valid=%b want 0 0", fault, out_valid);
    else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_instr !== 32'h00500093)
      $display("FAIL fault_recover: got valid=%b pc=%h instr=%h want 1 0 00500093", out_valid, out_pc, out_instr);
    else n_pass++;
  endtask

  task automatic test_range_fault;
    reset_dut();
    s_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++;
      if (s_out_valid !== 1'b1 || s_out_pc !== 64'(4 * k) || s_out_instr !== imem[k])
        $display("FAIL range_stream[%0d]: got valid=%b pc=%h instr=%h want 1 %h %h",
                 k, s_out_valid, s_out_pc, s_out_instr, 64'(4 * k), imem[k]);
      else n_pass++;
    end
    s_out_ready = 1'b0;
    tick();
    n_total++; if (s_fault !== 1'b0 || s_out_pc !== 64'h8)
      $display("FAIL range_pre_fault: got fault=%b pc=%h want 0 8", s_fault, s_out_pc);
    else n_pass++;
    tick();
    n_total++; if (s_fault !== 1'b1 || s_fault_pc !== 64'h10)
      $display("FAIL range_fault: got fault=%b fault_pc=%h want 1 10", s_fault, s_fault_pc);
    else n_pass++;
    n_total++; if (s_out_valid !== 1'b1 || s_out_pc !== 64'h8)
      $display("FAIL range_drain0: got valid=%b pc=%h want 1 8", s_out_valid, s_out_pc);
    else n_pass++;
    s_out_ready = 1'b1;
    tick();
    n_total++; if (s_out_valid !== 1'b1 || s_out_pc !== 64'hc || s_out_instr !== imem[3] || s_fault !== 1'b1)
      $display("FAIL range_drain1: got valid=%b pc=%h instr=%h fault=%b want 1 c %h 1",
               s_out_valid, s_out_pc, s_out_instr, s_fault, imem[3]);
    else n_pass++;
`ifdef FETCH_PERF_EN
    n_total++; if (s_perf_fetched !== 64'd3) $display("FAIL range_perf_fetched: got %0d want 3", s_perf_fetched); else n_pass++;
    n_total++; if (s_perf_stall !== 64'd1) $display("FAIL range_perf_stall: got %0d want 1", s_perf_stall); else n_pass++;
`endif
    rst = 1'b1;
    #1;
    n_total++; if (s_fault !== 1'b0 || s_out_valid !== 1'b0 || s_imem_addr !== 64'h0)
      $display("FAIL range_async_reset: got fault=%b valid=%b pc=%h want 0 0 0", s_fault, s_out_valid, s_imem_addr);
    else n_pass++;
  endtask

  // Randomized run against a transaction model: a queue for the buffer,
  // a PC, and a fault flag, advanced once per cycle from the fetch rules.
  task automatic test_random;
    ent_t        q[$];
    logic [63:0] m_pc, m_fault_pc, m_fetched, m_stall, tgt;
    logic        m_fault, rdy, redir, pop;
    int          sel;
    reset_dut();
    m_pc = 64'h0; m_fault = 1'b0; m_fault_pc = 64'h0; m_fetched = 0; m_stall = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      n_total++;
      if (out_valid !== (q.size() != 0))
        $display("FAIL rand_valid@%0d: got %b want %b", cyc, out_valid, q.size() != 0);
      else n_pass++;
      if (q.size() != 0) begin
        n_total++;
        if (out_pc !== q[0].pc || out_instr !== q[0].instr)
          $display("FAIL rand_head@%0d: got pc=%h instr=%h want %h %h", cyc, out_pc, out_instr, q[0].pc, q[0].instr);
        else n_pass++;
      end
      n_total++;
      if (fault !== m_fault || imem_addr !== m_pc)
        $display("FAIL rand_state@%0d: got fault=%b pc=%h want %b %h", cyc, fault, imem_addr, m_fault, m_pc);
      else n_pass++;
      if (m_fault) begin
        n_total++;
        if (fault_pc !== m_fault_pc) $display("FAIL rand_fault_pc@%0d: got %h want %h", cyc, fault_pc, m_fault_pc);
        else n_pass++;
      end
`ifdef FETCH_PERF_EN
      n_total++;
      if (perf_fetched !== m_fetched || perf_stall !== m_stall)
        $display("FAIL rand_perf@%0d: got %0d/%0d want %0d/%0d", cyc, perf_fetched, perf_stall, m_fetched, m_stall);
      else n_pass++;
`endif
      rdy   = ($urandom_range(0, 9) < 7);
      redir = m_fault ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 99) < 6);
      sel   = $urandom_range(0, 7);
      case (sel)
        5:       tgt = {54'd0, 8'($urandom), 2'($urandom_range(1, 3))};
        6:       tgt = 64'h3f0 + 64'(4 * $urandom_range(0, 3));
        7:       tgt = {$urandom, $urandom} & ~64'h3;
        default: tgt = {54'd0, 8'($urandom), 2'b00};
      endcase
      out_ready      = rdy;
      redirect_valid = redir;
      redirect_pc    = tgt;

      pop = (q.size() != 0) && rdy;
      if (!m_fault && q.size() == D && !pop) m_stall++;
      if (pop) m_fetched++;
      if (redir) begin
        q.delete();
        m_pc = tgt;
        if (tgt[1:0] != 2'b00) begin
          m_fault = 1'b1; m_fault_pc = tgt;
        end else begin
          m_fault = 1'b0;
        end
      end else begin
        if (pop) void'(q.pop_front());
        if (!m_fault) begin
          if (m_pc[1:0] != 2'b00 || m_pc[63:2] >= 62'd256) begin
            m_fault = 1'b1; m_fault_pc = m_pc;
          end else if (q.size() < D) begin
            q.push_back('{pc: m_pc, instr: imem[m_pc[9:2]]});
            m_pc = m_pc + 64'd4;
          end
        end
      end
      tick();
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    redirect_valid   = 1'b0;
    redirect_pc      = 64'h0;
    out_ready        = 1'b0;
    s_redirect_valid = 1'b0;
    s_redirect_pc    = 64'h0;
    s_out_ready      = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = $urandom;
    imem[0] = 32'h00500093;
    imem[1] = 32'h00a00113;
    imem[2] = 32'h002081b3;
    imem[3] = 32'h00302023;
    imem[4] = 32'h00002203;

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fault_redirect();
    test_range_fault();
    test_random();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
